// File: rtl/counter_monitor.sv
// Consumer-side checker for the 4-bit mode counter: runs a reference model and flags divergences.
// Optional COUNTER_MONITOR_RESYNC_EN reloads the model from the counter's Q on a Q mismatch.
module counter_monitor #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ERR_CNT_W = 8,
   parameter int unsigned CHK_CNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 ENABLE,
   input  logic [1:0]           MODO,
   input  logic [WIDTH-1:0]     D,
   input  logic [WIDTH-1:0]     Q,
   input  logic                 RCO,
   input  logic                 LOAD,
   output logic                 ERROR,
   output logic [2:0]           ERR_FLAGS,
   output logic [ERR_CNT_W-1:0] ERR_COUNT,
   output logic [CHK_CNT_W-1:0] CHECK_COUNT,
   output logic                 FIRST_ERR_VALID,
   output logic [WIDTH-1:0]     FIRST_ERR_Q,
   output logic [WIDTH-1:0]     FIRST_ERR_EXP
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFailed
   } state_t;

   state_t state_q;

   logic [WIDTH-1:0] q_exp;
   logic             rco_exp;
   logic             load_exp;

   logic             comparing;
   logic [2:0]       mism;
   logic [WIDTH-1:0] base;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] q_nxt;
   logic             rco_nxt;
   logic             load_nxt;

   // Compare against the model values produced on the previous edge.
   always_comb begin
      comparing = (state_q != StIdle);
      mism      = 3'b000;
      if (comparing) begin
         mism = {Q != q_exp, RCO != rco_exp, LOAD != load_exp};
      end
   end

   always_comb begin
      base = q_exp;
`ifdef COUNTER_MONITOR_RESYNC_EN
      // Adopt the counter's value so one slip is reported once, not every cycle after.
      if (mism[2]) begin
         base = Q;
      end
`endif
      sum      = '0;
      q_nxt    = base;
      rco_nxt  = 1'b0;
      load_nxt = 1'b0;
      if (ENABLE) begin
         unique case (MODO)
            2'b00: begin
               sum     = {1'b0, base} + (WIDTH+1)'(3);
               q_nxt   = sum[WIDTH-1:0];
               rco_nxt = sum[WIDTH];
            end
            2'b01: begin
               q_nxt   = base - WIDTH'(1);
               rco_nxt = (base == '0);
            end
            2'b10: begin
               q_nxt   = base + WIDTH'(1);
               rco_nxt = (base == '1);
            end
            2'b11: begin
               q_nxt    = D;
               load_nxt = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q         <= StIdle;
         q_exp           <= '0;
         rco_exp         <= 1'b0;
         load_exp        <= 1'b0;
         ERROR           <= 1'b0;
         ERR_FLAGS       <= 3'b000;
         ERR_COUNT       <= '0;
         CHECK_COUNT     <= '0;
         FIRST_ERR_VALID <= 1'b0;
         FIRST_ERR_Q     <= '0;
         FIRST_ERR_EXP   <= '0;
      end else begin
         q_exp     <= q_nxt;
         rco_exp   <= rco_nxt;
         load_exp  <= load_nxt;
         ERROR     <= |mism;
         ERR_FLAGS <= mism;
         unique case (state_q)
            StIdle: begin
               state_q <= StRun;
            end
            StRun, StFailed: begin
               if (CHECK_COUNT != '1) begin
                  CHECK_COUNT <= CHECK_COUNT + CHK_CNT_W'(1);
               end
               if ((|mism) && (ERR_COUNT != '1)) begin
                  ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
               end
               // Snapshot is taken only on the RUN->FAILED edge and frozen after.
               if ((|mism) && (state_q == StRun)) begin
                  state_q         <= StFailed;
                  FIRST_ERR_VALID <= 1'b1;
                  FIRST_ERR_Q     <= Q;
                  FIRST_ERR_EXP   <= q_exp;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
